// File: rtl/z180_bus_master_if.sv
// Client handshake and Z8S180 pin bundle for z180_bus_master.
// The master modport is the controller; the slave modport is the surrounding logic and pins.
interface z180_bus_master_if;
    logic        req;
    logic        we;
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ack;
    logic        err;
    logic        busy;
    logic        busreq_n;
    logic        busack_n;
    logic [19:0] a_out;
    logic        a_oe;
    logic [7:0]  d_in;
    logic [7:0]  d_out;
    logic        d_oe;
    logic        ce_n;
    logic        oe_n;
    logic        we_n;

    modport master (
        input  req, we, addr, wdata, busack_n, d_in,
        output rdata, ack, err, busy, busreq_n, a_out, a_oe, d_out, d_oe, ce_n, oe_n, we_n
    );

    modport slave (
        output req, we, addr, wdata, busack_n, d_in,
        input  rdata, ack, err, busy, busreq_n, a_out, a_oe, d_out, d_oe, ce_n, oe_n, we_n
    );
endinterface

// File: rtl/z180_bus_master.sv
// Borrows the Z8S180 bus via /BUSREQ-/BUSACK and runs single-byte SRAM/ROM read/write cycles.
// Optional: define BUSMASTER_TIMEOUT_EN to give up (ack+err) when /BUSACK never arrives.
module z180_bus_master #(
    parameter int STROBE_CYCLES = 3,
    parameter int RELEASE_IDLE  = 8,
    parameter int TIMEOUT       = 1023
) (
    input  logic              hwclk,
    input  logic              reset,
    z180_bus_master_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_SETUP, S_STROBE, S_HOLD, S_OWN, S_REL
    } state_t;

    localparam logic [3:0] STRB_LAST = 4'(STROBE_CYCLES - 1);
    localparam logic [7:0] IDLE_LAST = 8'(RELEASE_IDLE - 1);

    if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_chk_strobe
        $error("STROBE_CYCLES must be 1..15");
    end
    if (RELEASE_IDLE < 1 || RELEASE_IDLE > 255) begin : g_chk_release
        $error("RELEASE_IDLE must be 1..255");
    end
    if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_chk_timeout
        $error("TIMEOUT must be 1..1023");
    end

    state_t      state_q, state_nxt;
    logic        sync_p0, ack_s;
    logic [3:0]  strb_cnt;
    logic [7:0]  idle_cnt;
    logic        lost_q;
    logic        we_q;
    logic [19:0] addr_q;
    logic [7:0]  wdata_q;
    logic        latch_en, we_sel, tmo_hit;
    logic [19:0] addr_sel;
    logic [7:0]  wdata_sel;
    logic        busreq_n_nxt, a_oe_nxt, d_oe_nxt, ce_n_nxt, oe_n_nxt, we_n_nxt;
    logic        ack_nxt, err_nxt, busy_nxt;

    // A request from OWN goes straight to SETUP, so the live inputs bypass the latch.
    assign latch_en  = bus.req && ((state_q == S_IDLE) || (state_q == S_OWN && !ack_s));
    assign we_sel    = latch_en ? bus.we    : we_q;
    assign addr_sel  = latch_en ? bus.addr  : addr_q;
    assign wdata_sel = latch_en ? bus.wdata : wdata_q;

`ifdef BUSMASTER_TIMEOUT_EN
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);
    logic [9:0] tmo_cnt;

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) tmo_cnt <= '0;
        else       tmo_cnt <= (state_q == S_REQ) ? tmo_cnt + 10'd1 : '0;
    end

    assign tmo_hit = (state_q == S_REQ) && ack_s && (tmo_cnt == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    // /BUSACK is asynchronous to hwclk
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b1;
            ack_s   <= 1'b1;
        end else begin
            sync_p0 <= bus.busack_n;
            ack_s   <= sync_p0;
        end
    end

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            strb_cnt <= '0;
            idle_cnt <= '0;
            lost_q   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_nxt;
            strb_cnt <= (state_q == S_STROBE && state_nxt == S_STROBE) ? strb_cnt + 4'd1 : '0;
            idle_cnt <= (state_q == S_OWN && state_nxt == S_OWN) ? idle_cnt + 8'd1 : '0;
            lost_q   <= (state_nxt == S_SETUP) ? 1'b0
                      : (lost_q | (ack_s & (state_q inside {S_SETUP, S_STROBE})));
            if (latch_en) begin
                we_q    <= bus.we;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:   if (bus.req) state_nxt = S_REQ;
            S_REQ:    if (!ack_s) state_nxt = S_SETUP;
                      else if (tmo_hit) state_nxt = S_IDLE;
            S_SETUP:  state_nxt = S_STROBE;
            S_STROBE: if (strb_cnt == STRB_LAST) state_nxt = S_HOLD;
            // A grant withdrawn mid-cycle still lets the cycle finish, then gives the bus back.
            S_HOLD:   state_nxt = (lost_q || ack_s) ? S_REL : S_OWN;
            S_OWN:    if (ack_s) state_nxt = S_REL;
                      else if (bus.req) state_nxt = S_SETUP;
                      else if (idle_cnt == IDLE_LAST) state_nxt = S_REL;
            S_REL:    if (ack_s) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busreq_n_nxt = (state_nxt == S_IDLE) || (state_nxt == S_REL);
        a_oe_nxt     = state_nxt inside {S_SETUP, S_STROBE, S_HOLD, S_OWN};
        d_oe_nxt     = we_sel && (state_nxt inside {S_SETUP, S_STROBE, S_HOLD});
        ce_n_nxt     = !(state_nxt == S_STROBE);
        oe_n_nxt     = !(state_nxt == S_STROBE && !we_sel);
        we_n_nxt     = !(state_nxt == S_STROBE && we_sel);
        ack_nxt      = (state_nxt == S_HOLD) || tmo_hit;
        err_nxt      = tmo_hit;
        busy_nxt     = !((state_nxt == S_IDLE) || (state_nxt == S_OWN));
    end

    // Every pin and client output is a flop so reset forces the bus idle without waiting for a clock.
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            bus.busreq_n <= 1'b1;
            bus.ce_n     <= 1'b1;
            bus.oe_n     <= 1'b1;
            bus.we_n     <= 1'b1;
            bus.a_oe     <= 1'b0;
            bus.d_oe     <= 1'b0;
            bus.a_out    <= '0;
            bus.d_out    <= '0;
            bus.rdata    <= '0;
            bus.ack      <= 1'b0;
            bus.err      <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            bus.busreq_n <= busreq_n_nxt;
            bus.ce_n     <= ce_n_nxt;
            bus.oe_n     <= oe_n_nxt;
            bus.we_n     <= we_n_nxt;
            bus.a_oe     <= a_oe_nxt;
            bus.d_oe     <= d_oe_nxt;
            bus.ack      <= ack_nxt;
            bus.err      <= err_nxt;
            bus.busy     <= busy_nxt;
            if (state_nxt == S_SETUP) begin
                bus.a_out <= addr_sel;
                bus.d_out <= wdata_sel;
            end
            if (state_q == S_STROBE && strb_cnt == STRB_LAST && !we_q)
                bus.rdata <= bus.d_in;
        end
    end

endmodule

// File: doc/z180_bus_master.md
# z180_bus_master

Bus-mastering controller that lets FPGA-side logic borrow the Z8S180 external bus. It requests the bus from the CPU with /BUSREQ and waits for /BUSACK. Once granted, it runs single-byte memory read or write cycles to the shared SRAM/ROM space by driving A[19:0], D[7:0], /CE, /OE and /WE. It returns the bus to the CPU after a configurable idle period. It sits between FPGA client logic (loaders, debug monitor) and the top-level CPU/memory pins.

## Interface
Parameters:
- STROBE_CYCLES, 3, hwclk cycles /CE with /OE or /WE held low (1..15)
- RELEASE_IDLE, 8, idle hwclk cycles in OWN before returning bus (1..255)
- TIMEOUT, 1023, hwclk cycles to wait for /BUSACK (used only with BUSMASTER_TIMEOUT_EN)

Ports:
- hwclk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  1  client request; sampled only when busy=0
- we  in  1  1=write, 0=read; latched with req
- addr  in  20  target address; latched with req
- wdata  in  8  write data; latched with req
- rdata  out  8  read data; valid while ack=1, held until next read
- ack  out  1  one-cycle completion pulse
- err  out  1  one-cycle, coincident with ack; bus never granted
- busy  out  1  1 = request not accepted this cycle
- busreq_n  out  1  to CPU /BUSREQ
- busack_n  in  1  from CPU /BUSACK, asynchronous
- a_out  out  20  address to pins
- a_oe  out  1  address pin output enable
- d_in  in  8  data pins
- d_out  out  8  data to pins
- d_oe  out  1  data pin output enable
- ce_n, oe_n, we_n  out  1 each  memory strobes

## Operation
- busack_n passes through a 2-flop synchronizer (ack_s). All outputs are registered.
- Reset values:
  - busreq_n=1, ce_n=oe_n=we_n=1
  - a_oe=d_oe=0, a_out=0, d_out=0
  - rdata=0, ack=0, err=0, busy=0
  - state IDLE
- States and transitions:
  - IDLE: busy=0. On req: latch we/addr/wdata, set busreq_n=0, go to REQ.
  - REQ: busy=1. When ack_s=0, go to SETUP.
  - SETUP: 1 cycle. a_out=addr, a_oe=1, d_out=wdata, d_oe=we, all strobes high. Go to STROBE.
  - STROBE: STROBE_CYCLES cycles. ce_n=0, plus oe_n=0 for a read or we_n=0 for a write. On the last cycle a read captures d_in into rdata. Go to HOLD.
  - HOLD: 1 cycle. Strobes high, address and data still driven, ack=1. Go to OWN.
  - OWN: busy=0, busreq_n=0, a_oe=1, d_oe=0.
    - req: latch the request, go to SETUP (back-to-back, no re-arbitration).
    - RELEASE_IDLE consecutive cycles without req: go to REL.
  - REL: busy=1. a_oe=0, d_oe=0, busreq_n=1. When ack_s=1, go to IDLE.
- Drive rules:
  - d_oe is 1 only in SETUP, STROBE and HOLD of a write.
  - a_oe is never 1 unless ack_s=0 was seen in REQ.
- req while busy=1 is ignored. The client holds req until busy=0.
- If busack_n deasserts while the bus is owned (protocol violation), the current cycle completes. The block then enters REL.
- Reset mid-operation: all strobes and enables go inactive and busreq_n=1 immediately, asynchronously. No ack is issued.

## Timing
- req accepted in IDLE: busreq_n low on the next edge.
- /BUSACK to SETUP: 2 synchronizer cycles plus 1.
- Latency from SETUP entry to ack: 1 + STROBE_CYCLES + 1 cycles. Default 5.
- Back-to-back from OWN: req at cycle n, SETUP at n+1, ack at n+1+STROBE_CYCLES+1.
- Idle counter clears on any accepted req. Release happens exactly RELEASE_IDLE cycles after HOLD.
- Address is stable from SETUP through HOLD, bracketing each strobe by at least 1 cycle on each side.

## Configuration
- BUSMASTER_TIMEOUT_EN defined:
  - A 10-bit counter runs in REQ.
  - If ack_s is still 1 after TIMEOUT cycles: ack=1, err=1 for one cycle, busreq_n=1, return to IDLE.
  - No bus pins are ever driven on a timeout.
- Undefined: REQ waits indefinitely, and err is tied to 0.

## Test plan
- Read: req, we=0, addr=0x00100, busack_n falls 4 cycles later, model returns 0xA5 → oe_n low exactly 3 cycles, ack with rdata=0xA5, we_n stays 1.
- Write: we=1, addr=0xFFFFF, wdata=0x3C → d_oe=1 SETUP..HOLD, we_n low 3 cycles, d_out=0x3C, address stable, ack=1 with err=0.
- Back-to-back: two reads issued in OWN → busreq_n never rises between them; second ack arrives 5 cycles after its req.
- Release: no req after ack → busreq_n rises 8 cycles after HOLD, a_oe=0 the same cycle, IDLE after busack_n returns high.
- Timeout (macro on): busack_n held 1 → ack=err=1 at 1023 cycles, busreq_n=1, a_oe never 1.
- Reset asserted mid-STROBE → ce_n, oe_n and we_n all 1 and busreq_n=1 immediately; after reset release, a new req completes normally.
